dmem_responder: RTL and testbench
=================================

# dmem_responder

Memory-stage data-memory responder for the 5-stage RISC-V pipeline. It accepts a load or store request from the EX/MEM register fields and drives a byte-enabled, word-wide data SRAM port that has a variable wait-state handshake. It returns aligned, sign- or zero-extended load data for the MEM/WB `MemReadData` field. While an access is outstanding it asserts `stall` to freeze the pipeline.

## Interface
- `ADDR_W`, 9: SRAM word-address width. `mem_addr = req_addr[ADDR_W+1:2]`; higher address bits are ignored, so addresses wrap.
- `TIMEOUT`, 15: maximum number of ISSUE cycles spent waiting for `mem_ready` before an error response.
- `clk`  in  1  clock. All state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  MEM stage holds a memory instruction.
- `req_read`  in  1  EX/MEM `MemRead`.
- `req_write`  in  1  EX/MEM `MemWrite`.
- `req_addr`  in  32  EX/MEM `Alu_Result` (byte address).
- `req_wdata`  in  32  EX/MEM `RD_Two`.
- `req_func3`  in  3  EX/MEM `func3`.
- `stall`  out  1  freeze PC, IF/ID, ID/EX and EX/MEM.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_rdata`  out  32  extended load data; 0 for stores and errors.
- `rsp_err`  out  1  misaligned, illegal func3, read+write both set, or timeout.
- `mem_en`  out  1  SRAM request.
- `mem_we`  out  4  byte write enables; 0 for reads.
- `mem_addr`  out  ADDR_W  SRAM word address.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_rdata`  in  32  SRAM read word, valid when `mem_ready`=1.
- `mem_ready`  in  1  SRAM completes the access this cycle.

## Operation
- **States:** IDLE, ISSUE, DONE.
- **Accept condition:** in IDLE, a request is accepted when `req_valid && (req_read || req_write)`. Otherwise the block stays in IDLE, with `stall`=0.
- **Error checks at accept:** the following go straight to DONE with `rsp_err`=1 and no SRAM access:
  - `req_read && req_write` both set;
  - func3 not in {000, 001, 010, 100, 101};
  - stores with func3 100 or 101;
  - misalignment: a halfword with `addr[0]`=1, or a word with `addr[1:0]`≠0.
- **Good request:** the request is latched into internal registers and the block moves to ISSUE.
- **ISSUE:**
  - `mem_en`=1 and the SRAM outputs are driven from the latched request.
  - On `mem_ready`: latch the extended data and go to DONE.
  - The wait counter increments each cycle. When `mem_ready`=0 and the counter reaches `TIMEOUT`-1, go to DONE with `rsp_err`=1.
- **DONE:** `rsp_valid`=1 for exactly one cycle, then return to IDLE. Request inputs are ignored in DONE.
- **Store lanes:**
  - SB: byte replicated to all 4 lanes, `mem_we = 1 << addr[1:0]`.
  - SH: halfword replicated, `mem_we` = 0011 when `addr[1]`=0, else 1100.
  - SW: `mem_we` = 1111.
- **Load lanes:** select the byte or half by `addr[1:0]` / `addr[1]`. LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.
- **Outputs while not active:** SRAM outputs are all 0 outside ISSUE.

## Timing
- **Reset values:** `stall`, `rsp_valid`, `rsp_rdata`, `rsp_err`, `mem_en`, `mem_we`, `mem_addr` and `mem_wdata` are all 0. State is IDLE and the counter is 0.
- **Asynchronous reset:** `reset_n` low mid-access drops `mem_en` immediately and discards the access. No response is generated.
- **`stall` (combinational):** 1 in IDLE when accepting, and 1 throughout ISSUE. It is 0 in DONE, so the pipeline advances on the DONE edge.
- **Latency:**
  - Zero-wait access (`mem_ready`=1 in the first ISSUE cycle): stall for 2 cycles, `rsp_valid` in cycle 3.
  - Each wait state adds one cycle.
  - Error detected at accept: stall for 1 cycle, DONE in cycle 2.
- **Back-to-back:** a new request in the cycle after DONE is accepted with no extra bubble.
- **Registered outputs:** `rsp_rdata` and `rsp_err` are registered. They hold their value through DONE and clear to 0 on re-entering IDLE.
- **Timeout and late ready:** at the timeout boundary, `mem_ready` arriving in the same cycle the counter reaches `TIMEOUT`-1 is treated as success.

## Structure
- Add the following to the shared pipeline package next to the stage register structs:
  - the state enum;
  - func3 localparams (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`).
- Sub-module `load_store_align` (combinational) holds the lane replication, `mem_we` generation, load extract/extend and the misalign/func3 legality check. The top level keeps the FSM, counter and registers.

## Test plan
- **Zero-wait SW:** `req_addr`=0x10, data 0xDEADBEEF, `mem_ready` tied 1 → `mem_addr`=4, `mem_we`=1111, `stall` high for 2 cycles, `rsp_valid` in cycle 3, `rsp_err`=0.
- **LB sign-extend:** word 0x80FF7F01 at 0x10, LB at 0x13 → `rsp_rdata`=0xFFFFFF80; LBU at 0x13 → 0x00000080; LH at 0x12 → 0xFFFF80FF.
- **SB lane:** SB at 0x11, data 0x000000AB → `mem_we`=0010, `mem_wdata`=0xABABABAB.
- **Wait states:** `mem_ready` asserted after 3 low cycles → `stall` for 5 cycles, `rsp_valid` in cycle 6, correct data.
- **Errors:**
  - LW at 0x12 → `rsp_err`=1 after 1 stall cycle, `mem_en` never asserted.
  - `mem_ready` held 0 → `rsp_err`=1 after `TIMEOUT` ISSUE cycles, `rsp_rdata`=0.
- **Reset mid-ISSUE:** `reset_n` low → `mem_en` and `stall` drop with no clock edge, no `rsp_valid`. The next request after release completes normally.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared pipeline definitions used by the MEM-stage data-memory responder.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } dmem_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response and SRAM port bundle between the MEM stage, the responder and the data SRAM.
interface dmem_responder_if #(
    parameter int ADDR_W = 9
);
    logic              req_valid;
    logic              req_read;
    logic              req_write;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic [2:0]        req_func3;

    logic              stall;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    logic              mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ready;

    modport master (
        output req_valid, req_read, req_write, req_addr, req_wdata, req_func3,
        output mem_rdata, mem_ready,
        input  stall, rsp_valid, rsp_rdata, rsp_err,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_read, req_write, req_addr, req_wdata, req_func3,
        input  mem_rdata, mem_ready,
        output stall, rsp_valid, rsp_rdata, rsp_err,
        output mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_responder_align.sv
// Byte-lane steering for stores, load extraction/extension, and access legality.
module load_store_align
    import dmem_responder_pkg::*;
(
    input  logic [2:0]  i_req_func3,
    input  logic [1:0]  i_req_off,
    input  logic        i_req_write,
    input  logic [31:0] i_req_wdata,
    output logic        o_legal,
    output logic [3:0]  o_mem_we,
    output logic [31:0] o_mem_wdata,
    input  logic [2:0]  i_ld_func3,
    input  logic [1:0]  i_ld_off,
    input  logic [31:0] i_mem_rdata,
    output logic [31:0] o_ld_data
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Unsigned widths cannot be stored; halves need even and words need zero offsets.
    always_comb begin
        o_legal = 1'b0;
        case (i_req_func3)
            F3_B:    o_legal = 1'b1;
            F3_H:    o_legal = !i_req_off[0];
            F3_W:    o_legal = (i_req_off == 2'b00);
            F3_BU:   o_legal = !i_req_write;
            F3_HU:   o_legal = !i_req_write && !i_req_off[0];
            default: o_legal = 1'b0;
        endcase
    end

    always_comb begin
        o_mem_we    = 4'b0000;
        o_mem_wdata = 32'h0;
        if (i_req_write) begin
            case (i_req_func3)
                F3_B: begin
                    o_mem_wdata = {4{i_req_wdata[7:0]}};
                    o_mem_we    = 4'b0001 << i_req_off;
                end
                F3_H: begin
                    o_mem_wdata = {2{i_req_wdata[15:0]}};
                    o_mem_we    = i_req_off[1] ? 4'b1100 : 4'b0011;
                end
                F3_W: begin
                    o_mem_wdata = i_req_wdata;
                    o_mem_we    = 4'b1111;
                end
                default: begin
                    o_mem_wdata = 32'h0;
                    o_mem_we    = 4'b0000;
                end
            endcase
        end
    end

    always_comb begin
        w_byte = 8'h0;
        case (i_ld_off)
            2'd0: w_byte = i_mem_rdata[7:0];
            2'd1: w_byte = i_mem_rdata[15:8];
            2'd2: w_byte = i_mem_rdata[23:16];
            2'd3: w_byte = i_mem_rdata[31:24];
            default: w_byte = 8'h0;
        endcase
        w_half = i_ld_off[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
        o_ld_data = 32'h0;
        case (i_ld_func3)
            F3_B:    o_ld_data = {{24{w_byte[7]}}, w_byte};
            F3_H:    o_ld_data = {{16{w_half[15]}}, w_half};
            F3_W:    o_ld_data = i_mem_rdata;
            F3_BU:   o_ld_data = {24'h0, w_byte};
            F3_HU:   o_ld_data = {16'h0, w_half};
            default: o_ld_data = 32'h0;
        endcase
    end
endmodule

// File: rtl/dmem_responder.sv
// MEM-stage responder: accepts one load/store, runs the SRAM wait-state handshake, stalls the pipe meanwhile.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    dmem_responder_if.slave   bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    dmem_state_t       r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_we;
    logic [31:0]       r_wdata;
    logic [2:0]        r_func3;
    logic [1:0]        r_off;
    logic              r_write;
    logic [31:0]       r_rdata;
    logic              r_err;

    logic        w_accept;
    logic        w_issue;
    logic        w_legal;
    logic [3:0]  w_we;
    logic [31:0] w_wdata;
    logic [31:0] w_ld_data;
    logic        w_unused_addr;

    // Gating with reset_n keeps stall low while the pipeline itself is held in reset.
    assign w_accept = reset_n && (r_state == ST_IDLE) && bus.req_valid
                      && (bus.req_read || bus.req_write);
    assign w_issue  = (r_state == ST_ISSUE);
    assign w_unused_addr = ^bus.req_addr[31:ADDR_W+2];

    assign bus.stall     = w_accept || w_issue;
    assign bus.rsp_valid = (r_state == ST_DONE);
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_err   = r_err;
    assign bus.mem_en    = w_issue;
    assign bus.mem_we    = w_issue ? r_we    : 4'b0000;
    assign bus.mem_addr  = w_issue ? r_addr  : '0;
    assign bus.mem_wdata = w_issue ? r_wdata : 32'h0;

    load_store_align u_align (
        .i_req_func3 (bus.req_func3),
        .i_req_off   (bus.req_addr[1:0]),
        .i_req_write (bus.req_write),
        .i_req_wdata (bus.req_wdata),
        .o_legal     (w_legal),
        .o_mem_we    (w_we),
        .o_mem_wdata (w_wdata),
        .i_ld_func3  (r_func3),
        .i_ld_off    (r_off),
        .i_mem_rdata (bus.mem_rdata),
        .o_ld_data   (w_ld_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_we    <= 4'b0000;
            r_wdata <= 32'h0;
            r_func3 <= 3'b000;
            r_off   <= 2'b00;
            r_write <= 1'b0;
            r_rdata <= 32'h0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_rdata <= 32'h0;
                        r_cnt   <= '0;
                        if ((bus.req_read && bus.req_write) || !w_legal) begin
                            r_err   <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_err   <= 1'b0;
                            r_addr  <= bus.req_addr[ADDR_W+1:2];
                            r_we    <= w_we;
                            r_wdata <= w_wdata;
                            r_func3 <= bus.req_func3;
                            r_off   <= bus.req_addr[1:0];
                            r_write <= bus.req_write;
                            r_state <= ST_ISSUE;
                        end
                    end
                end
                // A ready on the final allowed cycle still wins over the timeout.
                ST_ISSUE: begin
                    if (bus.mem_ready) begin
                        r_rdata <= r_write ? 32'h0 : w_ld_data;
                        r_state <= ST_DONE;
                    end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        r_err   <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_rdata <= 32'h0;
                    r_err   <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed loads/stores against a behavioural wait-state SRAM.
module tb_dmem_responder;
    localparam int ADDR_W  = 9;
    localparam int TIMEOUT = 15;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } rsp_t;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;
    int   waitStates;
    int   issueCycles;
    logic [31:0] memArr [0:511];
    rsp_t expQ [$];

    logic        capEn;
    logic [3:0]  capWe;
    logic [31:0] capAddr;
    logic [31:0] capWdata;

    dmem_responder_if #(.ADDR_W(ADDR_W)) bus ();

    dmem_responder #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // SRAM model: raises ready after waitStates low ISSUE cycles and commits writes on that cycle.
    initial begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h0;
        issueCycles   = 0;
        forever begin
            @(negedge clk);
            if (bus.mem_en === 1'b1) begin
                bus.mem_ready = (issueCycles >= waitStates);
                bus.mem_rdata = bus.mem_ready ? memArr[bus.mem_addr] : 32'h0;
                if (bus.mem_ready) begin
                    for (int i = 0; i < 4; i++)
                        if (bus.mem_we[i]) memArr[bus.mem_addr][8*i +: 8] = bus.mem_wdata[8*i +: 8];
                end
                issueCycles++;
            end else begin
                bus.mem_ready = 1'b0;
                bus.mem_rdata = 32'h0;
                issueCycles   = 0;
            end
        end
    end

    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) begin
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_rsp actual=rsp_valid required=no_response");
                end else begin
                    e = expQ.pop_front();
                    checkOutput("rsp_rdata", bus.rsp_rdata, e.data);
                    checkOutput("rsp_err", {31'b0, bus.rsp_err}, {31'b0, e.err});
                end
            end
        end
    end

    task automatic applyStimulus(input string name, input logic rd, input logic wr,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [2:0] f3, input int waits,
                                 input logic [31:0] expData, input logic expErr, input int expStall,
                                 output logic oEn, output logic [3:0] oWe,
                                 output logic [31:0] oAddr, output logic [31:0] oWdata);
        int   stallCnt;
        logic done;
        rsp_t e;
        @(negedge clk);
        checkOutput({name, "_idle_valid"}, {31'b0, bus.rsp_valid}, 32'h0);
        checkOutput({name, "_idle_rdata"}, bus.rsp_rdata, 32'h0);
        waitStates    = waits;
        bus.req_valid = 1'b1;
        bus.req_read  = rd;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_func3 = f3;
        e.data = expData;
        e.err  = expErr;
        expQ.push_back(e);
        stallCnt = 0;
        done     = 1'b0;
        oEn      = 1'b0;
        oWe      = 4'b0000;
        oAddr    = 32'h0;
        oWdata   = 32'h0;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            if (bus.stall === 1'b1) begin
                stallCnt++;
                if (bus.mem_en === 1'b1 && !oEn) begin
                    oEn    = 1'b1;
                    oWe    = bus.mem_we;
                    oAddr  = 32'(bus.mem_addr);
                    oWdata = bus.mem_wdata;
                end
                @(negedge clk);
            end else begin
                done = 1'b1;
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s_timeout actual=stall_stuck required=stall_release", name);
        end
        checkOutput({name, "_stall_cycles"}, stallCnt, expStall);
        checkOutput({name, "_valid_cycle"}, {31'b0, bus.rsp_valid}, 32'h1);
        bus.req_valid = 1'b0;
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        waitStates    = 0;
        reset_n       = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_read  = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;
        bus.req_func3 = 3'b000;
        for (int i = 0; i < 512; i++) memArr[i] = 32'h0;
        #2;
        checkOutput("rst_stall", {31'b0, bus.stall}, 32'h0);
        checkOutput("rst_valid", {31'b0, bus.rsp_valid}, 32'h0);
        checkOutput("rst_err", {31'b0, bus.rsp_err}, 32'h0);
        checkOutput("rst_rdata", bus.rsp_rdata, 32'h0);
        checkOutput("rst_mem_en", {31'b0, bus.mem_en}, 32'h0);
        checkOutput("rst_mem_bus", {bus.mem_we, 19'(bus.mem_addr), 9'h0} | bus.mem_wdata, 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        applyStimulus("sw0", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 0, 32'h0, 1'b0, 2,
                      capEn, capWe, capAddr, capWdata);
        checkOutput("sw0_we", {28'h0, capWe}, 32'hF);
        checkOutput("sw0_addr", capAddr, 32'h4);
        checkOutput("sw0_wdata", capWdata, 32'hDEADBEEF);
        applyStimulus("lw0", 1'b1, 1'b0, 32'h10, 32'h0, 3'b010, 0, 32'hDEADBEEF, 1'b0, 2,
                      capEn, capWe, capAddr, capWdata);
        checkOutput("lw0_we", {28'h0, capWe}, 32'h0);
        applyStimulus("sw1", 1'b0, 1'b1, 32'h10, 32'h80FF7F01, 3'b010, 0, 32'h0, 1'b0, 2,
                      capEn, capWe, capAddr, capWdata);
        applyStimulus("lb13", 1'b1, 1'b0, 32'h13, 32'h0, 3'b000, 0, 32'hFFFFFF80, 1'b0, 2,
                      capEn, capWe, capAddr, capWdata);
        applyStimulus("lbu13", 1'b1, 1'b0, 32'h13, 32'h0, 3'b100, 0, 32'h00000080, 1'b0, 2,
                      capEn, capWe, capAddr, capWdata);
        applyStimulus("lh12", 1'b1, 1'b0, 32'h12, 32'h0, 3'b001, 0, 32'hFFFF80FF, 1'b0, 2,
                      capEn, capWe, capAddr, capWdata);
        applyStimulus("lhu_wait3", 1'b1, 1'b0, 32'h10, 32'h0, 3'b101, 3, 32'h00007F01, 1'b0, 5,
                      capEn, capWe, capAddr, capWdata);
        applyStimulus("sb11", 1'b0, 1'b1, 32'h11, 32'h000000AB, 3'b000, 0, 32'h0, 1'b0, 2,
                      capEn, capWe, capAddr, capWdata);
        checkOutput("sb11_we", {28'h0, capWe}, 32'h2);
        checkOutput("sb11_wdata", capWdata, 32'hABABABAB);
        applyStimulus("lw_after_sb", 1'b1, 1'b0, 32'h10, 32'h0, 3'b010, 1, 32'h80FFAB01, 1'b0, 3,
                      capEn, capWe, capAddr, capWdata);
        applyStimulus("sh16", 1'b0, 1'b1, 32'h16, 32'h1234CAFE, 3'b001, 0, 32'h0, 1'b0, 2,
                      capEn, capWe, capAddr, capWdata);
        checkOutput("sh16_we", {28'h0, capWe}, 32'hC);
        checkOutput("sh16_wdata", capWdata, 32'hCAFECAFE);
        checkOutput("sh16_addr", capAddr, 32'h5);
        applyStimulus("lh16", 1'b1, 1'b0, 32'h16, 32'h0, 3'b001, 0, 32'hFFFFCAFE, 1'b0, 2,
                      capEn, capWe, capAddr, capWdata);

        applyStimulus("lw_misalign", 1'b1, 1'b0, 32'h12, 32'h0, 3'b010, 0, 32'h0, 1'b1, 1,
                      capEn, capWe, capAddr, capWdata);
        checkOutput("lw_misalign_no_mem", {31'b0, capEn}, 32'h0);
        applyStimulus("bad_f3", 1'b1, 1'b0, 32'h10, 32'h0, 3'b011, 0, 32'h0, 1'b1, 1,
                      capEn, capWe, capAddr, capWdata);
        applyStimulus("sbu_illegal", 1'b0, 1'b1, 32'h10, 32'h55, 3'b100, 0, 32'h0, 1'b1, 1,
                      capEn, capWe, capAddr, capWdata);
        checkOutput("sbu_no_mem", {31'b0, capEn}, 32'h0);
        applyStimulus("rd_and_wr", 1'b1, 1'b1, 32'h10, 32'h0, 3'b010, 0, 32'h0, 1'b1, 1,
                      capEn, capWe, capAddr, capWdata);
        applyStimulus("timeout", 1'b1, 1'b0, 32'h10, 32'h0, 3'b010, 100, 32'h0, 1'b1, TIMEOUT + 1,
                      capEn, capWe, capAddr, capWdata);
        applyStimulus("late_ready", 1'b1, 1'b0, 32'h14, 32'h0, 3'b010, TIMEOUT - 1, 32'hCAFE0000, 1'b0,
                      TIMEOUT + 1, capEn, capWe, capAddr, capWdata);
        applyStimulus("wrap", 1'b1, 1'b0, 32'h00000814, 32'h0, 3'b010, 0, 32'hCAFE0000, 1'b0, 2,
                      capEn, capWe, capAddr, capWdata);
        checkOutput("wrap_addr", capAddr, 32'h5);

        @(negedge clk);
        waitStates    = 100;
        bus.req_valid = 1'b1;
        bus.req_read  = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 32'h10;
        bus.req_func3 = 3'b010;
        @(negedge clk);
        #1;
        checkOutput("mid_issue_en", {31'b0, bus.mem_en}, 32'h1);
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("reset_drop_en", {31'b0, bus.mem_en}, 32'h0);
        checkOutput("reset_drop_stall", {31'b0, bus.stall}, 32'h0);
        bus.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        applyStimulus("post_reset", 1'b1, 1'b0, 32'h10, 32'h0, 3'b010, 0, 32'h80FFAB01, 1'b0, 2,
                      capEn, capWe, capAddr, capWdata);

        repeat (3) @(negedge clk);
        checkOutput("queue_drained", expQ.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
